// File: rtl/spi_pkg.sv
// Shared widths, FSM state encoding and SPI mode record for the loopback subsystem.
// Latency: n/a (declarations only); backpressure: n/a.
package spi_pkg;

    localparam int DATA_W     = 8;
    localparam int NUM_SLAVES = 3;
    localparam int CNT_W      = $clog2(DATA_W);
    localparam int SEL_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

endpackage

// File: rtl/spi_slave_core.sv
// One SPI slave: parallel load, MSB-first shift on each active sclk bit, word capture on done.
// Latency: shifts in the same clk edge as the master; no backpressure (master paces the bus).
module spi_slave_core
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              ss_i,
    input  logic              done_i,
    input  logic              sclk_i,
    input  logic              cpol_i,
    input  logic              mosi_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic              miso_o,
    output logic [DATA_W-1:0] data_out_o
);

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              shift_en;

    // sclk away from its idle level marks a bit slot in progress
    assign shift_en = ss_i && (sclk_i != cpol_i);

    always_comb begin
        sh_d  = sh_q;
        out_d = out_q;
        if (load_i) begin
            sh_d = data_in_i;
        end else if (shift_en) begin
            sh_d = {sh_q[DATA_W-2:0], mosi_i};
        end
        if (done_i) begin
            out_d = {sh_q[DATA_W-2:0], mosi_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q  <= '0;
            out_q <= '0;
        end else begin
            sh_q  <= sh_d;
            out_q <= out_d;
        end
    end

    assign miso_o     = ss_i & sh_q[DATA_W-1];
    assign data_out_o = out_q;

endmodule

// File: rtl/spi_loopback_system.sv
// SPI master plus NUM_SLAVES slaves on an internal bus; full-duplex 8-bit exchange per enable.
// Latency: results valid 9 clk edges after enable sampled high; enable is a level request, no backpressure.
module spi_loopback_system
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] masterDataIN,
    input  logic [DATA_W-1:0] slave0DataIN,
    input  logic [DATA_W-1:0] slave1DataIN,
    input  logic [DATA_W-1:0] slave2DataIN,
    output logic [DATA_W-1:0] masterDataOUT,
    output logic [DATA_W-1:0] slave0DataOUT,
    output logic [DATA_W-1:0] slave1DataOUT,
    output logic [DATA_W-1:0] slave2DataOUT,
    input  logic [SEL_W-1:0]  slaveno,
    input  logic              enable,
    input  logic              cpha,
    input  logic              cpol
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] m_sh_q, m_sh_d;
    logic [DATA_W-1:0] m_out_q, m_out_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    mode_t             mode_q, mode_d;
    logic              sclk_q, sclk_d;
    logic              lead_q;
    logic              load;
    logic              done;

    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] s_din  [NUM_SLAVES];
    logic [DATA_W-1:0] s_dout [NUM_SLAVES];
    logic [NUM_SLAVES-1:0] s_miso;

    assign s_din[0] = slave0DataIN;
    assign s_din[1] = slave1DataIN;
    assign s_din[2] = slave2DataIN;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_sh_d  = m_sh_q;
        m_out_d = m_out_q;
        sel_d   = sel_q;
        mode_d  = mode_q;
        sclk_d  = mode_q.cpol;
        load    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                sclk_d = cpol;
                if (enable) begin
                    m_sh_d  = masterDataIN;
                    mode_d  = '{cpol: cpol, cpha: cpha};
                    sel_d   = slaveno;
                    cnt_d   = '0;
                    load    = 1'b1;
                    sclk_d  = ~cpol;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    m_sh_d = {m_sh_q[DATA_W-2:0], miso};
                    cnt_d  = cnt_q + CNT_W'(1);
                    sclk_d = ~mode_q.cpol;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        m_out_d = {m_sh_q[DATA_W-2:0], miso};
                        done    = 1'b1;
                        sclk_d  = mode_q.cpol;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            m_sh_q  <= '0;
            m_out_q <= '0;
            sel_q   <= '0;
            mode_q  <= '0;
            sclk_q  <= cpol;
            lead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_sh_q  <= m_sh_d;
            m_out_q <= m_out_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            sclk_q  <= sclk_d;
            lead_q  <= m_sh_d[DATA_W-1];
        end
    end

    // cpha=1 drives the bit from the leading-edge launch flop; it carries the same MSB,
    // so the delivered word does not depend on the mode
    assign mosi = mode_q.cpha ? lead_q : m_sh_q[DATA_W-1];
    assign miso = |s_miso;

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_slave
        logic ss;
        assign ss = (state_q == ST_SHIFT) && (sel_q == SEL_W'(k));

        spi_slave_core u_slave (
            .clk        (clk),
            .reset      (reset),
            .load_i     (load && (slaveno == SEL_W'(k))),
            .ss_i       (ss),
            .done_i     (done && (sel_q == SEL_W'(k))),
            .sclk_i     (sclk_q),
            .cpol_i     (mode_q.cpol),
            .mosi_i     (mosi),
            .data_in_i  (s_din[k]),
            .miso_o     (s_miso[k]),
            .data_out_o (s_dout[k])
        );
    end

    assign masterDataOUT = m_out_q;
    assign slave0DataOUT = s_dout[0];
    assign slave1DataOUT = s_dout[1];
    assign slave2DataOUT = s_dout[2];

endmodule

// File: tb/tb_spi_loopback_system.sv
// Self-checking bench: directed vector table, hand-written multi-cycle corners, randomized
// transfers checked against a word-level exchange model.
module tb_spi_loopback_system;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] masterDataIN, slave0DataIN, slave1DataIN, slave2DataIN;
    logic [7:0] masterDataOUT, slave0DataOUT, slave1DataOUT, slave2DataOUT;
    logic [1:0] slaveno;
    logic       enable, cpha, cpol;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_m;
    logic [7:0] exp_s [3];

    spi_loopback_system dut (
        .clk           (clk),
        .reset         (reset),
        .masterDataIN  (masterDataIN),
        .slave0DataIN  (slave0DataIN),
        .slave1DataIN  (slave1DataIN),
        .slave2DataIN  (slave2DataIN),
        .masterDataOUT (masterDataOUT),
        .slave0DataOUT (slave0DataOUT),
        .slave1DataOUT (slave1DataOUT),
        .slave2DataOUT (slave2DataOUT),
        .slaveno       (slaveno),
        .enable        (enable),
        .cpha          (cpha),
        .cpol          (cpol)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] m, s0, s1, s2;
        logic [1:0] sn;
        logic       pol, pha;
        int         hold;
        logic [7:0] em, e0, e1, e2;
    } vec_t;

    vec_t vt [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_m"},  masterDataOUT, exp_m);
        chk({tag, "_s0"}, slave0DataOUT, exp_s[0]);
        chk({tag, "_s1"}, slave1DataOUT, exp_s[1]);
        chk({tag, "_s2"}, slave2DataOUT, exp_s[2]);
    endtask

    // Word-level model: a completed exchange swaps the two words; an unselected bus reads zero
    task automatic model_xfer(input logic [7:0] md, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [1:0] sn);
        logic [7:0] sd [3];
        sd[0] = s0; sd[1] = s1; sd[2] = s2;
        if (sn < 2'd3) begin
            exp_m     = sd[sn];
            exp_s[sn] = md;
        end else begin
            exp_m = 8'h00;
        end
    endtask

    initial begin
        vt[0] = '{8'h69, 8'hA5, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0,  9, 8'hA5, 8'h69, 8'h00, 8'h00};
        vt[1] = '{8'h3C, 8'h11, 8'hD6, 8'h00, 2'd1, 1'b0, 1'b1,  9, 8'hD6, 8'h69, 8'h3C, 8'h00};
        vt[2] = '{8'h81, 8'h11, 8'h22, 8'h5A, 2'd2, 1'b1, 1'b1,  9, 8'h5A, 8'h69, 8'h3C, 8'h81};
        vt[3] = '{8'h77, 8'hFD, 8'h22, 8'h5A, 2'd0, 1'b1, 1'b0,  9, 8'hFD, 8'h77, 8'h3C, 8'h81};
        vt[4] = '{8'hE0, 8'hFD, 8'h42, 8'h5A, 2'd1, 1'b0, 1'b1,  9, 8'h42, 8'h77, 8'hE0, 8'h81};
        vt[5] = '{8'hC3, 8'hFD, 8'h42, 8'h18, 2'd2, 1'b0, 1'b0, 14, 8'h18, 8'h77, 8'hE0, 8'hC3};
        vt[6] = '{8'h99, 8'h66, 8'h42, 8'h18, 2'd0, 1'b0, 1'b0,  5, 8'h18, 8'h77, 8'hE0, 8'hC3};
        vt[7] = '{8'hFF, 8'h66, 8'h42, 8'h18, 2'd3, 1'b1, 1'b0,  9, 8'h00, 8'h77, 8'hE0, 8'hC3};
        vt[8] = '{8'h5B, 8'hB4, 8'h42, 8'h18, 2'd0, 1'b1, 1'b1,  9, 8'hB4, 8'h5B, 8'hE0, 8'hC3};

        reset = 1'b1; enable = 1'b0; cpol = 1'b0; cpha = 1'b0; slaveno = 2'd0;
        masterDataIN = 8'h00; slave0DataIN = 8'h00; slave1DataIN = 8'h00; slave2DataIN = 8'h00;
        step(); step();
        reset = 1'b0;
        step();
        exp_m = 8'h00; exp_s[0] = 8'h00; exp_s[1] = 8'h00; exp_s[2] = 8'h00;
        chk_all("reset");

        // Directed table
        for (int i = 0; i < 9; i++) begin
            masterDataIN = vt[i].m;  slave0DataIN = vt[i].s0;
            slave1DataIN = vt[i].s1; slave2DataIN = vt[i].s2;
            slaveno = vt[i].sn; cpol = vt[i].pol; cpha = vt[i].pha;
            enable = 1'b1;
            repeat (vt[i].hold) step();
            enable = 1'b0;
            step();
            exp_m = vt[i].em; exp_s[0] = vt[i].e0; exp_s[1] = vt[i].e1; exp_s[2] = vt[i].e2;
            chk_all($sformatf("vec%0d", i));
        end

        // Latency: nothing visible after 8 edges, result present after the 9th
        masterDataIN = 8'h2D; slave1DataIN = 8'hC7; slaveno = 2'd1; cpol = 1'b0; cpha = 1'b1;
        enable = 1'b1;
        repeat (8) step();
        chk("lat8_m", masterDataOUT, exp_m);
        chk("lat8_s1", slave1DataOUT, exp_s[1]);
        step();
        model_xfer(8'h2D, slave0DataIN, 8'hC7, slave2DataIN, 2'd1);
        chk("lat9_m", masterDataOUT, exp_m);
        chk("lat9_s1", slave1DataOUT, exp_s[1]);
        enable = 1'b0;
        step();

        // Enable held past completion: one transfer only
        masterDataIN = 8'h6E; slave2DataIN = 8'h91; slaveno = 2'd2; cpol = 1'b1; cpha = 1'b0;
        enable = 1'b1;
        repeat (9) step();
        model_xfer(8'h6E, slave0DataIN, slave1DataIN, 8'h91, 2'd2);
        chk_all("hold_done");
        masterDataIN = 8'h00; slave0DataIN = 8'hFF; slave2DataIN = 8'hFF; slaveno = 2'd0;
        repeat (10) step();
        chk_all("hold_noretrig");
        enable = 1'b0;
        step();

        // Reset in the middle of a transfer
        masterDataIN = 8'hAA; slave0DataIN = 8'h55; slaveno = 2'd0; cpol = 1'b0; cpha = 1'b0;
        enable = 1'b1;
        repeat (5) step();
        reset = 1'b1; enable = 1'b0;
        step();
        reset = 1'b0;
        step();
        exp_m = 8'h00; exp_s[0] = 8'h00; exp_s[1] = 8'h00; exp_s[2] = 8'h00;
        chk_all("midreset");

        // Randomized transfers, inputs scrambled after load to prove capture
        for (int n = 0; n < 40; n++) begin
            logic [7:0] md, s0, s1, s2;
            logic [1:0] sn;
            logic       complete;
            int         hold;
            md = 8'($urandom); s0 = 8'($urandom); s1 = 8'($urandom); s2 = 8'($urandom);
            sn = 2'($urandom_range(0, 3));
            complete = ($urandom_range(0, 3) != 0);
            hold = complete ? int'($urandom_range(9, 12)) : int'($urandom_range(1, 8));
            masterDataIN = md; slave0DataIN = s0; slave1DataIN = s1; slave2DataIN = s2;
            slaveno = sn; cpol = 1'($urandom); cpha = 1'($urandom);
            enable = 1'b1;
            step();
            masterDataIN = 8'($urandom); slave0DataIN = 8'($urandom);
            slave1DataIN = 8'($urandom); slave2DataIN = 8'($urandom);
            slaveno = 2'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
            repeat (hold - 1) step();
            enable = 1'b0;
            step();
            if (complete) model_xfer(md, s0, s1, s2, sn);
            chk_all($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
